// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the EXE->MEM pipeline register
// Contents:
//   occ_e      : occupancy of the elastic stage (EMPTY, ONE, TWO)
//   WB_EN/MEM_R/MEM_W : bit positions inside the control vector
//   payload_w  : width of the packed {ctrl, alu_result, st_val, dest} vector
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int WB_EN = 0;
  localparam int MEM_R = 1;
  localparam int MEM_W = 2;

  function automatic int payload_w(input int ctrl_w, input int data_w, input int dest_w);
    return ctrl_w + 2 * data_w + dest_w;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - load-enabled payload register with async reset and sync clear
// Ports:
//   clk, rst : clock, asynchronous active-high reset (q -> 0)
//   clr      : synchronous clear to 0, wins over load
//   load     : capture d on the next rising edge
//   d, q     : W-bit payload in / held payload out
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/elastic_exe_mem_reg.sv
// rtl/elastic_exe_mem_reg.sv - elastic EXE->MEM pipeline register with flush and optional skid slot
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : synchronous squash of every held entry (drops a concurrent input)
//   in_valid / in_ready  : execute-side handshake
//   in_ctrl, in_alu_result, in_st_val, in_dest : execute-side payload
//   out_valid / out_ready: memory-side handshake
//   out_ctrl, out_alu_result, out_st_val, out_dest : memory-side payload
//     (out_ctrl reads 0 whenever out_valid is 0)
// SKID=1 adds a second slot so in_ready can come straight from a flop.
import pipe_pkg::*;

module elastic_exe_mem_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_st_val,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_st_val,
  output logic [DEST_W-1:0] out_dest
);

  localparam int PW = payload_w(CTRL_W, DATA_W, DEST_W);

  occ_e          state;
  occ_e          state_nx;
  logic [PW-1:0] in_pl;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          main_load;
  logic          skid_load;
  logic          in_fire;
  logic          out_fire;

  assign in_pl     = {in_ctrl, in_alu_result, in_st_val, in_dest};
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_pl;
    if (flush) begin
      // Slots are cleared by the slot's own clr; only occupancy moves here.
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nx  = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            // Without a skid slot in_ready is low here, so this branch is dead.
            if (SKID != 0) begin
              state_nx  = TWO;
              skid_load = 1'b1;
            end
          end else if (out_fire) begin
            state_nx = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nx  = ONE;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  pipe_slot #(.W(PW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;

      pipe_slot #(.W(PW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .load (skid_load),
        .d    (in_pl),
        .q    (skid_q)
      );

      // Registered from the next occupancy so it is already low in the first
      // cycle spent in TWO; no combinational path from out_ready.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdy_q <= 1'b1;
        end else begin
          rdy_q <= (state_nx != TWO);
        end
      end

      assign in_ready = rdy_q;
    end else begin : g_noskid
      logic unused_skid_load;

      assign unused_skid_load = skid_load;
      assign skid_q           = '0;
      assign in_ready         = !out_valid | out_ready;
    end
  endgenerate

  assign out_ctrl       = out_valid ? main_q[PW-1 -: CTRL_W] : '0;
  assign out_alu_result = main_q[PW-CTRL_W-1 -: DATA_W];
  assign out_st_val     = main_q[DEST_W +: DATA_W];
  assign out_dest       = main_q[DEST_W-1:0];

endmodule

// File: tb/tb_elastic_exe_mem_reg.sv
// tb/tb_elastic_exe_mem_reg.sv - bench for elastic_exe_mem_reg, SKID=0 and SKID=1 side by side
module tb_elastic_exe_mem_reg;

  localparam int PW = 3 + 32 + 32 + 4;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        flush     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  in_ctrl   = '0;
  logic [31:0] in_alu    = '0;
  logic [31:0] in_st     = '0;
  logic [3:0]  in_dest   = '0;

  logic [1:0]  in_ready_w;
  logic [1:0]  out_valid_w;
  logic [2:0]  out_ctrl_w [2];
  logic [31:0] out_alu_w  [2];
  logic [31:0] out_st_w   [2];
  logic [3:0]  out_dest_w [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elastic_exe_mem_reg #(.DATA_W(32), .DEST_W(4), .CTRL_W(3), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_ctrl(in_ctrl), .in_alu_result(in_alu), .in_st_val(in_st), .in_dest(in_dest),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_ctrl(out_ctrl_w[0]), .out_alu_result(out_alu_w[0]),
    .out_st_val(out_st_w[0]), .out_dest(out_dest_w[0])
  );

  elastic_exe_mem_reg #(.DATA_W(32), .DEST_W(4), .CTRL_W(3), .SKID(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_ctrl(in_ctrl), .in_alu_result(in_alu), .in_st_val(in_st), .in_dest(in_dest),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_ctrl(out_ctrl_w[1]), .out_alu_result(out_alu_w[1]),
    .out_st_val(out_st_w[1]), .out_dest(out_dest_w[1])
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a FIFO of capacity 1+SKID per instance. Each negedge first
  // applies the transfers decided at the previous negedge (they happened at
  // the rising edge in between), then checks the outputs and decides the
  // transfers for the coming edge.
  logic [PW-1:0] mq [2][4];
  int            mcnt [2]     = '{0, 0};
  logic          pend_in [2]  = '{1'b0, 1'b0};
  logic          pend_out [2] = '{1'b0, 1'b0};
  logic          pend_flush   = 1'b0;
  logic [PW-1:0] pend_pl      = '0;
  int            fire_cnt [2] = '{0, 0};
  logic          count_en     = 1'b0;
  logic [PW-1:0] got_v;
  logic          exp_ready_v;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pend_flush) begin
        mcnt[i] = 0;
      end else begin
        if (pend_out[i] && mcnt[i] > 0) begin
          for (int j = 0; j < 3; j++) mq[i][j] = mq[i][j+1];
          mcnt[i]--;
        end
        if (pend_in[i] && mcnt[i] < 2) begin
          mq[i][mcnt[i]] = pend_pl;
          mcnt[i]++;
        end
      end

      got_v = {out_ctrl_w[i], out_alu_w[i], out_st_w[i], out_dest_w[i]};
      if (rst) begin
        mcnt[i]     = 0;
        pend_in[i]  = 1'b0;
        pend_out[i] = 1'b0;
        check($sformatf("u%0d reset outputs", i),
              {out_valid_w[i], in_ready_w[i], got_v}, {1'b0, 1'b1, {PW{1'b0}}});
      end else begin
        exp_ready_v = (i == 0) ? (mcnt[i] == 0 || out_ready) : (mcnt[i] < 2);
        check($sformatf("u%0d out_valid", i), out_valid_w[i], mcnt[i] != 0);
        check($sformatf("u%0d in_ready", i), in_ready_w[i], exp_ready_v);
        if (mcnt[i] != 0) check($sformatf("u%0d payload", i), got_v, mq[i][0]);
        else              check($sformatf("u%0d idle ctrl", i), out_ctrl_w[i], 3'b000);
        pend_in[i]  = in_valid && exp_ready_v;
        pend_out[i] = (mcnt[i] != 0) && out_ready;
        if (count_en && pend_in[i]) fire_cnt[i]++;
      end
    end
    pend_flush = flush && !rst;
    pend_pl    = {in_ctrl, in_alu, in_st, in_dest};
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] val;

    // Reset then idle
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d rst valid", i), out_valid_w[i], 1'b0);
      check($sformatf("u%0d rst ctrl", i), out_ctrl_w[i], 3'b000);
      check($sformatf("u%0d rst ready", i), in_ready_w[i], 1'b1);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      check("idle valid", out_valid_w, 2'b00);
      check("idle ready", in_ready_w, 2'b11);
    end

    // Streaming 1..8 with out_ready high: one cycle latency, no bubbles
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_alu   = 32'(k);
      in_st    = 32'(k * 3);
      in_dest  = 4'(k);
      in_ctrl  = 3'($urandom());
      cyc();
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d stream valid %0d", i, k), out_valid_w[i], 1'b1);
        check($sformatf("u%0d stream alu %0d", i, k), out_alu_w[i], 32'(k));
      end
    end
    in_valid = 1'b0;
    cyc();
    cyc();

    // Backpressure from cycle 3
    val = 32'hA;
    for (int c = 1; c <= 6; c++) begin
      in_valid  = 1'b1;
      in_alu    = val;
      in_dest   = 4'(c);
      in_ctrl   = 3'b011;
      val       = val + 1;
      out_ready = (c < 3);
      if (c == 3) begin
        fire_cnt[0] = 0;
        fire_cnt[1] = 0;
        count_en    = 1'b1;
        #1;
        check("u0 ready drops with out_ready", in_ready_w[0], 1'b0);
        check("u1 ready still high in ONE", in_ready_w[1], 1'b1);
      end
      cyc();
    end
    count_en = 1'b0;
    check("u0 accepted during stall", fire_cnt[0], 0);
    check("u1 accepted during stall", fire_cnt[1], 1);
    check("u1 ready low in TWO", in_ready_w[1], 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) cyc();

    // Held output under stall
    in_valid  = 1'b1;
    in_alu    = 32'hDEAD;
    in_dest   = 4'd7;
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("u0 hold valid", out_valid_w[0], 1'b1);
      check("u0 hold alu", out_alu_w[0], 32'hDEAD);
      check("u0 hold dest", out_dest_w[0], 4'd7);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    cyc();

    // Flush while u1 holds two entries, with a concurrent input
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 3'b001;
    in_alu    = 32'h100;
    cyc();
    in_alu = 32'h101;
    cyc();
    check("u1 full before flush", in_ready_w[1], 1'b0);
    flush   = 1'b1;
    in_ctrl = 3'b101;
    in_alu  = 32'h555;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush valid", out_valid_w, 2'b00);
    check("u1 flush ctrl", out_ctrl_w[1], 3'b000);
    check("u1 ready after flush", in_ready_w[1], 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      check("nothing after flush", out_valid_w, 2'b00);
    end

    // Asynchronous reset while u1 is in TWO
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 3'b110;
    in_alu    = 32'h200;
    cyc();
    in_alu = 32'h201;
    cyc();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("u1 async rst valid", out_valid_w[1], 1'b0);
    check("u1 async rst payload",
          {out_ctrl_w[1], out_alu_w[1], out_st_w[1], out_dest_w[1]}, {PW{1'b0}});
    check("u1 async rst ready", in_ready_w[1], 1'b1);
    cyc();
    cyc();
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_alu    = 32'h77;
    out_ready = 1'b1;
    cyc();
    check("resume valid", out_valid_w, 2'b11);
    check("u0 resume alu", out_alu_w[0], 32'h77);
    check("u1 resume alu", out_alu_w[1], 32'h77);

    // Random traffic against the FIFO model
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_ctrl   = 3'($urandom());
      in_alu    = $urandom();
      in_st     = $urandom();
      in_dest   = 4'($urandom());
      cyc();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
